// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Brief    : Shared types and default sizing for the UART TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    localparam int ARB_DATA_WIDTH = 8;
    localparam int ARB_NUM_REQ    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester / transmitter bundle around the UART TX arbiter.
//            master = arbiter side, slave = producers plus transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int DATA_WIDTH = ARB_DATA_WIDTH,
    parameter int NUM_REQ    = ARB_NUM_REQ
);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic [NUM_REQ-1:0]            done;
    logic                          tx_err;
    logic                          busy;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          send_en;
    logic                          Tx_Done;

    modport master (
        input  req, req_data, Tx_Done,
        output ack, done, tx_err, busy, tx_data, send_en
    );

    modport slave (
        output req, req_data, Tx_Done,
        input  ack, done, tx_err, busy, tx_data, send_en
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module   : uart_rr_picker
// Brief    : Combinational round-robin picker. Finds the first set request
//            at or above ptr, wrapping modulo NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Replicated vector: a window of NUM_REQ bits starting at ptr is the
    // request vector rotated so that bit 0 is the highest-priority source.
    logic [2*NUM_REQ-2:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    int                   w_off;
    int                   w_sum;

    assign w_dbl = {req[NUM_REQ-2:0], req};
    assign w_rot = w_dbl[ptr +: NUM_REQ];

    // Lowest set bit of the rotated window, mapped back to an absolute index.
    always_comb begin
        valid = 1'b0;
        w_off = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                valid = 1'b1;
                w_off = k;
            end
        end
        w_sum = int'(ptr) + w_off;
        if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
        end
        idx = IDX_W'(w_sum);
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter sharing one uart_data_tx among NUM_REQ byte
//            sources. One grant per transmitter completion; all outputs are
//            registered.
// Options  : UART_ARB_WDOG_EN - adds a Tx_Done watchdog (WDOG_CYCLES) that
//            aborts a stuck transfer with a tx_err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = ARB_DATA_WIDTH,
    parameter int NUM_REQ     = ARB_NUM_REQ
`ifdef UART_ARB_WDOG_EN
    ,
    parameter int WDOG_CYCLES = 2_000_000
`endif
) (
    input  logic               Clk,
    input  logic               Rst_n,
    uart_tx_arbiter_if.master  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_gidx;
    logic                  w_pick_valid;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_wdog_expire;

    logic [NUM_REQ-1:0]    r_ack,     w_ack_nxt;
    logic [NUM_REQ-1:0]    r_done,    w_done_nxt;
    logic                  r_tx_err,  w_tx_err_nxt;
    logic                  r_busy,    w_busy_nxt;
    logic                  r_send_en, w_send_en_nxt;
    logic [DATA_WIDTH-1:0] r_tx_data;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (bus.req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

`ifdef UART_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES);
    logic [WD_W-1:0] r_wdog_cnt;

    // Watchdog: cleared while launching (i.e. on entry to WAIT), counts WAIT cycles.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wdog_cnt <= '0;
        end else if (r_state == SEND) begin
            r_wdog_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end

    assign w_wdog_expire = (r_state == WAIT) &&
                           (r_wdog_cnt == WD_W'(WDOG_CYCLES - 1));
`else
    assign w_wdog_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one SEND cycle per grant, WAIT until completion.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_state_nxt = SEND;
            SEND:    w_state_nxt = WAIT;
            WAIT:    if (bus.Tx_Done || w_wdog_expire) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs. Tx_Done wins over
    // a coincident watchdog expiry.
    always_comb begin
        w_ack_nxt     = '0;
        w_done_nxt    = '0;
        w_tx_err_nxt  = 1'b0;
        w_send_en_nxt = 1'b0;
        w_busy_nxt    = (w_state_nxt != IDLE);
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_ack_nxt[w_pick_idx] = 1'b1;
                    w_send_en_nxt         = 1'b1;
                end
            end
            WAIT: begin
                if (bus.Tx_Done) begin
                    w_done_nxt[r_gidx] = 1'b1;
                end else if (w_wdog_expire) begin
                    w_tx_err_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_ack     <= '0;
            r_done    <= '0;
            r_tx_err  <= 1'b0;
            r_busy    <= 1'b0;
            r_send_en <= 1'b0;
        end else begin
            r_ack     <= w_ack_nxt;
            r_done    <= w_done_nxt;
            r_tx_err  <= w_tx_err_nxt;
            r_busy    <= w_busy_nxt;
            r_send_en <= w_send_en_nxt;
        end
    end

    // Grant datapath: latch winner and its word; advance pointer past it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_gidx    <= '0;
            r_tx_data <= '0;
            r_ptr     <= '0;
        end else begin
            if (r_state == IDLE && w_pick_valid) begin
                r_gidx    <= w_pick_idx;
                r_tx_data <= bus.req_data[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (r_state == SEND) begin
                r_ptr <= (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
            end
        end
    end

    assign bus.ack     = r_ack;
    assign bus.done    = r_done;
    assign bus.tx_err  = r_tx_err;
    assign bus.busy    = r_busy;
    assign bus.send_en = r_send_en;
    assign bus.tx_data = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter (4 sources).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    uart_tx_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

    uart_tx_arbiter #(
        .DATA_WIDTH  (8),
        .NUM_REQ     (4)
`ifdef UART_ARB_WDOG_EN
        ,
        .WDOG_CYCLES (16)
`endif
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Caller has req set in an IDLE cycle. Checks grant, quiet WAIT, done.
    task automatic serve(input logic [3:0] exp_ack, input logic [7:0] exp_data,
                         input logic [3:0] next_req, input int hold);
        tick();
        check("grant_ack", bus.ack, exp_ack);
        check("grant_send_en", bus.send_en, 1'b1);
        check("grant_tx_data", bus.tx_data, exp_data);
        check("grant_busy", bus.busy, 1'b1);
        bus.req = next_req;
        tick();
        check("wait_ack_send", {bus.ack, bus.send_en}, 5'b0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("no_regrant", {bus.ack, bus.send_en, bus.busy}, 6'b000001);
        end
        bus.Tx_Done = 1'b1;
        tick();
        bus.Tx_Done = 1'b0;
        check("done", bus.done, exp_ack);
        check("done_busy", bus.busy, 1'b0);
        check("done_tx_err", bus.tx_err, 1'b0);
    endtask

    initial begin
        bus.req      = 4'b0000;
        bus.req_data = {8'h5A, 8'hA5, 8'hC3, 8'h3C};
        bus.Tx_Done  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ack", bus.ack, 4'b0);
        check("rst_done", bus.done, 4'b0);
        check("rst_tx_err", bus.tx_err, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_send_en", bus.send_en, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        Rst_n = 1'b1;
        tick();

        // Tx_Done in IDLE is ignored
        bus.Tx_Done = 1'b1;
        tick();
        bus.Tx_Done = 1'b0;
        check("idle_txdone_done", bus.done, 4'b0);
        check("idle_txdone_busy", bus.busy, 1'b0);
        tick();

        // Single requester, long transfer; ptr -> 3
        bus.req = 4'b0100;
        serve(4'b0100, 8'hA5, 4'b0000, 99);
        tick();
        check("done_single_pulse", bus.done, 4'b0);

        // Reset mid-WAIT: grant 0 (ptr 3 wraps), then abort asynchronously
        bus.req = 4'b0001;
        tick();
        check("pre_rst_ack", bus.ack, 4'b0001);
        bus.req = 4'b0000;
        tick();
        check("pre_rst_busy", bus.busy, 1'b1);
        #2 Rst_n = 1'b0;
        #1;
        check("async_rst_outs", {bus.ack, bus.done, bus.tx_err, bus.busy, bus.send_en}, 11'b0);
        check("async_rst_tx_data", bus.tx_data, 8'h00);
        tick();
        tick();
        Rst_n = 1'b1;
        tick();

        // ptr back at 0: req 1001 -> 0 (stale ptr 1 would pick 3), then 1000 -> 3
        bus.req = 4'b1001;
        serve(4'b0001, 8'h3C, 4'b1000, 2);
        serve(4'b1000, 8'h5A, 4'b0000, 2);

        // All four requesting: 0,1,2,3,0 with wrap
        bus.req = 4'b1111;
        serve(4'b0001, 8'h3C, 4'b1111, 3);
        serve(4'b0010, 8'hC3, 4'b1111, 3);
        serve(4'b0100, 8'hA5, 4'b1111, 3);
        serve(4'b1000, 8'h5A, 4'b1111, 3);
        serve(4'b0001, 8'h3C, 4'b0000, 3);

        // Fairness: grant 1, then req 0011 searches from 2 and wraps to 0
        bus.req = 4'b0010;
        serve(4'b0010, 8'hC3, 4'b0000, 2);
        bus.req = 4'b0011;
        serve(4'b0001, 8'h3C, 4'b0000, 2);

        // Withdrawal: req[2] pulses while 0 is served, never acked
        bus.req = 4'b0001;
        tick();
        check("wd_ack0", bus.ack, 4'b0001);
        bus.req = 4'b0100;
        tick();
        check("wd_no_ack2_a", bus.ack, 4'b0);
        bus.req = 4'b0000;
        tick();
        check("wd_no_ack2_b", bus.ack, 4'b0);
        bus.req = 4'b0010;
        bus.Tx_Done = 1'b1;
        tick();
        bus.Tx_Done = 1'b0;
        check("wd_done0", bus.done, 4'b0001);
        tick();
        check("wd_ack1", bus.ack, 4'b0010);
        check("wd_tx_data1", bus.tx_data, 8'hC3);
        bus.req = 4'b0000;
        tick();
        bus.Tx_Done = 1'b1;
        tick();
        bus.Tx_Done = 1'b0;
        check("wd_done1", bus.done, 4'b0010);
        tick();

`ifdef UART_ARB_WDOG_EN
        // Watchdog expiry: tx_err 16 cycles after WAIT entry, no done
        bus.req = 4'b0100;
        tick();
        check("wdog_ack", bus.ack, 4'b0100);
        bus.req = 4'b0000;
        tick();
        repeat (15) tick();
        check("wdog_pre_err", {bus.tx_err, bus.busy}, 2'b01);
        tick();
        check("wdog_tx_err", bus.tx_err, 1'b1);
        check("wdog_busy", bus.busy, 1'b0);
        check("wdog_no_done", bus.done, 4'b0);
        tick();
        check("wdog_err_pulse", bus.tx_err, 1'b0);

        // Tx_Done on the expiry cycle wins
        bus.req = 4'b0100;
        tick();
        check("wdog2_ack", bus.ack, 4'b0100);
        bus.req = 4'b0000;
        tick();
        repeat (15) tick();
        bus.Tx_Done = 1'b1;
        tick();
        bus.Tx_Done = 1'b0;
        check("wdog2_done", bus.done, 4'b0100);
        check("wdog2_no_err", bus.tx_err, 1'b0);
        check("wdog2_busy", bus.busy, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_data_tx` transmitter between `NUM_REQ` independent byte sources.
- Accepts a level request plus data word from each source.
- Grants one source at a time and latches its word.
- Fires a single-cycle `send_en` into the transmitter.
- Holds off further grants until the transmitter reports `Tx_Done`.

It sits between the application-side producers (status reporters, loopback echo, command responder) and the single UART TX pin.

## Interface
- `DATA_WIDTH`, 8, width of one transmitted word; matches `uart_data_tx`.
- `NUM_REQ`, 4, number of requesters; legal range 2..16.
- `WDOG_CYCLES`, 2_000_000, `Tx_Done` timeout in `Clk` cycles; used only when `UART_ARB_WDOG_EN` is defined.
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-source level request.
- `req_data`  in  NUM_REQ*DATA_WIDTH  source i's word at bits [i*DATA_WIDTH +: DATA_WIDTH]; stable while `req[i]`=1.
- `ack`  out  NUM_REQ  one-hot, 1-cycle pulse: word of source i latched.
- `done`  out  NUM_REQ  one-hot, 1-cycle pulse: source i's word fully transmitted.
- `tx_err`  out  1  1-cycle pulse on watchdog abort.
- `busy`  out  1  high in any state other than IDLE.
- `tx_data`  out  DATA_WIDTH  word to `uart_data_tx.data`.
- `send_en`  out  1  1-cycle start pulse to `uart_data_tx.send_en`.
- `Tx_Done`  in  1  completion pulse from `uart_data_tx`.

## Operation
- FSM states: IDLE, SEND, WAIT.
- **IDLE**
  - If `req`≠0, the picker selects the first set bit searching upward from pointer `ptr`, wrapping modulo NUM_REQ.
  - On the clock edge: latch winner index `gidx` and `tx_data`; go to SEND.
  - If `req`=0, stay in IDLE.
- **SEND**
  - Lasts exactly one cycle; `ack[gidx]`=1 and `send_en`=1.
  - Update `ptr` to (gidx+1) mod NUM_REQ; go to WAIT.
- **WAIT**
  - On `Tx_Done`=1: go to IDLE; `done[gidx]`=1 in the following cycle.
- `Tx_Done` is ignored outside WAIT.
- `req` changes are ignored outside IDLE. A source dropping `req` before its grant is simply skipped.
- A source must deassert `req` on seeing `ack`, unless it has another word to send. A `req` still high when the FSM is back in IDLE counts as a new request.
- `tx_data` holds the last latched word until the next grant.
- Index widths are $clog2(NUM_REQ). Pointer wrap: `ptr`=NUM_REQ-1 advances to 0.

## Timing
- Reset values:
  - outputs: `ack`, `done`, `tx_err`, `busy`, `send_en` = 0; `tx_data` = 0.
  - internal: state = IDLE; `ptr` = 0; `gidx` = 0.
- All outputs are registered.
- Request sampled in IDLE at cycle N:
  - `ack` and `send_en` high in N+1.
  - `busy` high from N+1.
  - WAIT from N+2.
- `Tx_Done` at cycle M in WAIT: `done` pulse and `busy`=0 in M+1.
- Earliest re-arbitration is M+1; the next `send_en` comes at M+2.
- Reset assertion mid-transfer aborts immediately. No `done` or `ack` is emitted; the transmitter is reset by the same `Rst_n`.

## Configuration
- `UART_ARB_WDOG_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches WDOG_CYCLES-1 without `Tx_Done`, the FSM goes to IDLE.
  - `tx_err`=1 for one cycle; no `done`.
  - `ptr` has already advanced, so the failed source loses its turn.
  - `Tx_Done` in the same cycle as expiry wins: normal `done`, no error.
- Not defined: no counter is instantiated, `tx_err` is tied to 0, and WAIT waits indefinitely.

## Structure
- Package `uart_arb_pkg`:
  - state enum `arb_state_t` (IDLE, SEND, WAIT).
  - default constants `ARB_DATA_WIDTH`=8 and `ARB_NUM_REQ`=4.
- Sub-module `uart_rr_picker`: combinational; inputs `req` and `ptr`; outputs `valid` and `idx`. Replicated-vector search from `ptr` with wrap.
- The top level holds the FSM, data mux/latch, pointer, and optional watchdog.

## Test plan
- **Single requester:** `req`=4'b0100, data 8'hA5.
  - `ack`=4'b0100 and `send_en` at N+1; `tx_data`=8'hA5.
  - `Tx_Done` 100 cycles later gives `done`=4'b0100 one cycle after.
- **All four requesting continuously:** `ack` order 0,1,2,3,0. `ptr` wraps 3→0; never two grants without an intervening `Tx_Done`.
- **Pointer fairness:** after a grant to 1, `req`=4'b0011 → grant 1? no, grant 0 is skipped in favour of search from 2: wraps to 0. Required grant: 0.
- **Withdrawal:** `req[2]` pulsed high, then low while busy serving 0 → source 2 is never acked. `ack` at 1 only if `req[1]` is set.
- **Reset mid-WAIT:** `Rst_n` low asynchronously.
  - all outputs 0 immediately; `ptr`=0.
  - after release, `req`=4'b1000 → grant 3.
- **Watchdog** (macro on, WDOG_CYCLES=16): no `Tx_Done` → `tx_err` pulse 16 cycles after WAIT entry, `busy`=0 and no `done`. Repeat with `Tx_Done` on the expiry cycle → `done` and no `tx_err`.
